// File: rtl/elastic_pipe_register.sv
// rtl/elastic_pipe_register.sv - multi-stage valid/ready pipeline register with bubble collapse
module elastic_pipe_register #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clk_en,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic             full_from;
   logic [OW-1:0]    occ;

   // A stage can load unless it and every stage downstream of it is full and the sink stalls.
   always_comb begin
      rdy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         full_from = 1'b1;
         for (int j = i; j < DEPTH; j++) begin
            full_from = full_from & v[j];
         end
         rdy[i] = out_ready | ~full_from;
      end
   end

   always_comb begin
      src_v    = '0;
      src_v[0] = in_valid;
      src_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = v[i-1];
         src_d[i] = d[i-1];
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ = occ + OW'(v[i]);
      end
   end

   assign in_ready  = clk_en & ~flush & rdy[0];
   assign out_valid = clk_en & ~flush & v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign occupancy = occ;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d[i] <= RESET_VAL;
         end
      end else if (clk_en) begin
         if (flush) begin
            v <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (rdy[i]) begin
                  v[i] <= src_v[i];
                  d[i] <= src_d[i];
               end
            end
         end
      end
   end

endmodule
